// File: rtl/dcache_data_stage.sv
// Direct-mapped write-through L1 data array behind the dcache tag stage, one outstanding L2 transaction.
// Optional `DCACHE_PERF_COUNTERS_EN` adds load hit/miss counters on dd_perf_*.
module dcache_data_stage #(
  parameter int NUM_SETS    = 64,
  parameter int NUM_THREADS = 4,
  localparam int SET_W = $clog2(NUM_SETS),
  localparam int TW    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int TAG_W = 32 - 6 - SET_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dt_instruction_valid,
  input  logic             dt_is_load,
  input  logic             dt_is_vector,
  input  logic [15:0]      dt_mask_value,
  input  logic [TW-1:0]    dt_thread_idx,
  input  logic [31:0]      dt_request_addr,
  input  logic [511:0]     dt_store_value,
  input  logic             wb_rollback_en,
  input  logic [TW-1:0]    wb_rollback_thread_idx,
  output logic             dd_instruction_valid,
  output logic [TW-1:0]    dd_thread_idx,
  output logic [511:0]     dd_load_data,
  output logic             dd_rollback_en,
  output logic [TW-1:0]    dd_rollback_thread_idx,
  output logic             dd_suspend_thread,
  output logic             dd_wake_en,
  output logic [TW-1:0]    dd_wake_thread_idx,
  output logic             l2_req_valid,
  input  logic             l2_req_ready,
  output logic             l2_req_store,
  output logic [31:0]      l2_req_addr,
  output logic [511:0]     l2_req_data,
  output logic [63:0]      l2_req_byte_mask,
  input  logic             l2_resp_valid,
  input  logic [511:0]     l2_resp_data,
  output logic [31:0]      dd_perf_hit_count,
  output logic [31:0]      dd_perf_miss_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, next_state;

  logic [511:0]      data_array [NUM_SETS];
  logic [TAG_W-1:0]  tag_array  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_bits;

  logic [TW-1:0]    pend_thread;
  logic [SET_W-1:0] set_idx, pend_set;
  logic [TAG_W-1:0] req_tag, pend_tag;
  logic [511:0]     cur_line, store_data, bit_mask, merged_line;
  logic [63:0]      store_mask;
  logic             accept, busy, hit;
  logic             load_hit, load_miss, store_op, start_fill, start_store, fill_done;
  logic             unused_addr_bits;

  assign set_idx  = dt_request_addr[6 +: SET_W];
  assign req_tag  = dt_request_addr[31 -: TAG_W];
  assign pend_set = l2_req_addr[6 +: SET_W];
  assign pend_tag = l2_req_addr[31 -: TAG_W];
  assign cur_line = data_array[set_idx];
  assign unused_addr_bits = ^dt_request_addr[1:0];

  assign accept = dt_instruction_valid &&
                  !(wb_rollback_en && (wb_rollback_thread_idx == dt_thread_idx));
  assign busy   = (state != IDLE);
  assign hit    = valid_bits[set_idx] && (tag_array[set_idx] == req_tag);

  assign load_hit    = accept && dt_is_load && hit;
  assign load_miss   = accept && dt_is_load && !hit;
  assign store_op    = accept && !dt_is_load;
  assign start_fill  = load_miss && !busy;
  assign start_store = store_op && !busy;
  assign fill_done   = (state == WAIT) && l2_resp_valid && !l2_req_store;

  // Store data and byte enables positioned within the line, then merged over the current line.
  always_comb begin
    store_mask = '0;
    store_data = '0;
    bit_mask   = '0;
    if (dt_is_vector) begin
      for (int i = 0; i < 16; i++) begin
        if (dt_mask_value[i]) begin
          store_mask[4*i +: 4]  = 4'hF;
          store_data[32*i +: 32] = dt_store_value[32*i +: 32];
        end
      end
    end else begin
      store_mask[{dt_request_addr[5:2], 2'b00} +: 4]   = 4'hF;
      store_data[{dt_request_addr[5:2], 5'b00000} +: 32] = dt_store_value[31:0];
    end
    for (int b = 0; b < 64; b++) begin
      bit_mask[8*b +: 8] = {8{store_mask[b]}};
    end
    merged_line = (cur_line & ~bit_mask) | (store_data & bit_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_fill || start_store) next_state = REQ;
      REQ:     if (l2_req_ready) next_state = WAIT;
      WAIT:    if (l2_resp_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are latched when a transaction starts and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      l2_req_valid     <= 1'b0;
      l2_req_store     <= 1'b0;
      l2_req_addr      <= '0;
      l2_req_data      <= '0;
      l2_req_byte_mask <= '0;
      pend_thread      <= '0;
    end else begin
      l2_req_valid <= (next_state == REQ);
      if (start_fill || start_store) begin
        l2_req_store     <= start_store;
        l2_req_addr      <= {dt_request_addr[31:6], 6'b000000};
        l2_req_data      <= start_store ? store_data : '0;
        l2_req_byte_mask <= start_store ? store_mask : '0;
        pend_thread      <= dt_thread_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_done) begin
        data_array[pend_set] <= l2_resp_data;
        tag_array[pend_set]  <= pend_tag;
      end else if (start_store && hit) begin
        data_array[set_idx] <= merged_line;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          valid_bits <= '0;
    else if (fill_done) valid_bits[pend_set] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dd_instruction_valid   <= 1'b0;
      dd_thread_idx          <= '0;
      dd_load_data           <= '0;
      dd_rollback_en         <= 1'b0;
      dd_rollback_thread_idx <= '0;
      dd_suspend_thread      <= 1'b0;
      dd_wake_en             <= 1'b0;
      dd_wake_thread_idx     <= '0;
    end else begin
      dd_instruction_valid <= load_hit || (store_op && !busy);
      dd_rollback_en       <= load_miss || (store_op && busy);
      dd_suspend_thread    <= start_fill;
      dd_wake_en           <= fill_done;
      if (accept) begin
        dd_thread_idx          <= dt_thread_idx;
        dd_rollback_thread_idx <= dt_thread_idx;
      end
      if (load_hit) dd_load_data <= cur_line;
      if (fill_done) dd_wake_thread_idx <= pend_thread;
    end
  end

`ifdef DCACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count, miss_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit)  hit_count  <= hit_count + 32'd1;
      if (load_miss) miss_count <= miss_count + 32'd1;
    end
  end

  assign dd_perf_hit_count  = hit_count;
  assign dd_perf_miss_count = miss_count;
`else
  assign dd_perf_hit_count  = '0;
  assign dd_perf_miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_data_stage.sv
// Randomized bench for dcache_data_stage: a line-level cache + L2 memory model predicts every output each cycle.
// Directed opening sequence pins the model with hand-computed values.
`timescale 1ns/1ps
module tb_dcache_data_stage;

  localparam int NUM_SETS = 64;
  localparam int TW       = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          dt_instruction_valid, dt_is_load, dt_is_vector;
  logic [15:0]   dt_mask_value;
  logic [TW-1:0] dt_thread_idx;
  logic [31:0]   dt_request_addr;
  logic [511:0]  dt_store_value;
  logic          wb_rollback_en;
  logic [TW-1:0] wb_rollback_thread_idx;
  logic          dd_instruction_valid;
  logic [TW-1:0] dd_thread_idx;
  logic [511:0]  dd_load_data;
  logic          dd_rollback_en;
  logic [TW-1:0] dd_rollback_thread_idx;
  logic          dd_suspend_thread, dd_wake_en;
  logic [TW-1:0] dd_wake_thread_idx;
  logic          l2_req_valid, l2_req_ready, l2_req_store;
  logic [31:0]   l2_req_addr;
  logic [511:0]  l2_req_data;
  logic [63:0]   l2_req_byte_mask;
  logic          l2_resp_valid;
  logic [511:0]  l2_resp_data;
  logic [31:0]   dd_perf_hit_count, dd_perf_miss_count;

  always #5 clk = ~clk;

  dcache_data_stage #(.NUM_SETS(NUM_SETS), .NUM_THREADS(4)) dut (
    .clk(clk), .reset(reset),
    .dt_instruction_valid(dt_instruction_valid), .dt_is_load(dt_is_load),
    .dt_is_vector(dt_is_vector), .dt_mask_value(dt_mask_value),
    .dt_thread_idx(dt_thread_idx), .dt_request_addr(dt_request_addr),
    .dt_store_value(dt_store_value), .wb_rollback_en(wb_rollback_en),
    .wb_rollback_thread_idx(wb_rollback_thread_idx),
    .dd_instruction_valid(dd_instruction_valid), .dd_thread_idx(dd_thread_idx),
    .dd_load_data(dd_load_data), .dd_rollback_en(dd_rollback_en),
    .dd_rollback_thread_idx(dd_rollback_thread_idx), .dd_suspend_thread(dd_suspend_thread),
    .dd_wake_en(dd_wake_en), .dd_wake_thread_idx(dd_wake_thread_idx),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_store(l2_req_store),
    .l2_req_addr(l2_req_addr), .l2_req_data(l2_req_data), .l2_req_byte_mask(l2_req_byte_mask),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .dd_perf_hit_count(dd_perf_hit_count), .dd_perf_miss_count(dd_perf_miss_count)
  );

  typedef enum int {TXN_NONE, TXN_OFFERED, TXN_ACCEPTED} txn_phase_t;

  typedef struct packed {
    logic          iv, rb, susp, wake, l2v, l2s, ldchk;
    logic [TW-1:0] thr, rbt, wt;
    logic [511:0]  ld, l2d;
    logic [31:0]   l2a;
    logic [63:0]   l2m;
    logic [31:0]   hits, misses;
  } exp_t;

  // Model: cache lines, backing L2 memory and the single L2 transaction in flight.
  bit           m_valid [NUM_SETS];
  logic [19:0]  m_tag   [NUM_SETS];
  logic [511:0] m_data  [NUM_SETS];
  logic [511:0] mem [bit [25:0]];
  txn_phase_t   txn_phase = TXN_NONE;
  int           txn_delay;
  bit           txn_store;
  logic [31:0]  txn_addr;
  logic [TW-1:0] txn_thread;
  logic [511:0] txn_data;
  logic [63:0]  txn_mask;
  int unsigned  hit_cnt, miss_cnt;

  exp_t nx, ex;
  bit   check_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [511:0] d_line;

  function automatic logic [511:0] randLine();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] byteBits(input logic [63:0] m);
    logic [511:0] r;
    for (int b = 0; b < 64; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic logic [511:0] memRead(input logic [31:0] a);
    if (!mem.exists(a[31:6])) mem[a[31:6]] = randLine();
    return mem[a[31:6]];
  endfunction

  function automatic void storeFields(output logic [63:0] m, output logic [511:0] d);
    int w;
    m = '0;
    d = '0;
    if (dt_is_vector) begin
      for (int i = 0; i < 16; i++) begin
        if (dt_mask_value[i]) begin
          m[4*i +: 4]  = 4'hF;
          d[32*i +: 32] = dt_store_value[32*i +: 32];
        end
      end
    end else begin
      w = int'(dt_request_addr[5:2]);
      m[4*w +: 4]  = 4'hF;
      d[32*w +: 32] = dt_store_value[31:0];
    end
  endfunction

  task automatic compare(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Predict post-edge outputs from the current inputs and advance the model across the edge.
  task automatic modelStep();
    logic [5:0]   s;
    logic [19:0]  t;
    logic [63:0]  sm;
    logic [511:0] sd, bb;
    bit busy, acc, hit, start_new, new_store;
    nx = '0;
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) m_valid[i] = 1'b0;
      txn_phase = TXN_NONE;
      hit_cnt = 0;
      miss_cnt = 0;
      return;
    end
    busy = (txn_phase != TXN_NONE);
    acc  = dt_instruction_valid && !(wb_rollback_en && wb_rollback_thread_idx == dt_thread_idx);
    s    = dt_request_addr[11:6];
    t    = dt_request_addr[31:12];
    hit  = m_valid[s] && (m_tag[s] == t);
    storeFields(sm, sd);
    bb = byteBits(sm);
    start_new = 1'b0;
    new_store = 1'b0;
    if (acc) begin
      if (dt_is_load) begin
        if (hit) begin
          nx.iv = 1; nx.thr = dt_thread_idx; nx.ldchk = 1; nx.ld = m_data[s];
          hit_cnt++;
        end else begin
          miss_cnt++;
          nx.rb = 1; nx.rbt = dt_thread_idx;
          if (!busy) begin nx.susp = 1; start_new = 1; end
        end
      end else if (busy) begin
        nx.rb = 1; nx.rbt = dt_thread_idx;
      end else begin
        nx.iv = 1; nx.thr = dt_thread_idx;
        if (hit) m_data[s] = (m_data[s] & ~bb) | (sd & bb);
        start_new = 1; new_store = 1;
      end
    end
    if (txn_phase == TXN_OFFERED && l2_req_ready) begin
      txn_phase = TXN_ACCEPTED;
      txn_delay = $urandom_range(0, 6);
    end else if (txn_phase == TXN_ACCEPTED && l2_resp_valid) begin
      if (txn_store) begin
        mem[txn_addr[31:6]] = (memRead(txn_addr) & ~byteBits(txn_mask)) | (txn_data & byteBits(txn_mask));
      end else begin
        m_valid[txn_addr[11:6]] = 1'b1;
        m_tag[txn_addr[11:6]]   = txn_addr[31:12];
        m_data[txn_addr[11:6]]  = l2_resp_data;
        nx.wake = 1; nx.wt = txn_thread;
      end
      txn_phase = TXN_NONE;
    end
    if (start_new) begin
      txn_phase  = TXN_OFFERED;
      txn_store  = new_store;
      txn_addr   = {dt_request_addr[31:6], 6'b000000};
      txn_thread = dt_thread_idx;
      txn_data   = new_store ? sd : '0;
      txn_mask   = new_store ? sm : '0;
    end
    nx.l2v = (txn_phase == TXN_OFFERED);
    nx.l2s = txn_store;
    nx.l2a = txn_addr;
    nx.l2d = txn_data;
    nx.l2m = txn_mask;
    nx.hits = hit_cnt;
    nx.misses = miss_cnt;
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    ex = nx;
    check_en = 1'b1;
    #1;
  endtask

  task automatic checkOutput();
    compare("dd_instruction_valid", dd_instruction_valid, ex.iv);
    compare("dd_rollback_en", dd_rollback_en, ex.rb);
    compare("dd_suspend_thread", dd_suspend_thread, ex.susp);
    compare("dd_wake_en", dd_wake_en, ex.wake);
    compare("l2_req_valid", l2_req_valid, ex.l2v);
    if (ex.iv) compare("dd_thread_idx", dd_thread_idx, ex.thr);
    if (ex.iv && ex.ldchk) compare("dd_load_data", dd_load_data, ex.ld);
    if (ex.rb) compare("dd_rollback_thread_idx", dd_rollback_thread_idx, ex.rbt);
    if (ex.wake) compare("dd_wake_thread_idx", dd_wake_thread_idx, ex.wt);
    if (ex.l2v) begin
      compare("l2_req_addr", l2_req_addr, ex.l2a);
      compare("l2_req_store", l2_req_store, ex.l2s);
      compare("l2_req_byte_mask", l2_req_byte_mask, ex.l2m);
      if (ex.l2s) compare("l2_req_data", l2_req_data & byteBits(ex.l2m), ex.l2d & byteBits(ex.l2m));
    end
`ifdef DCACHE_PERF_COUNTERS_EN
    compare("perf_hit_count", dd_perf_hit_count, ex.hits);
    compare("perf_miss_count", dd_perf_miss_count, ex.misses);
`else
    compare("perf_hit_count_tied", dd_perf_hit_count, 32'd0);
    compare("perf_miss_count_tied", dd_perf_miss_count, 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  task automatic cyc(input bit v, input bit ld, input bit vec, input logic [TW-1:0] thr,
                     input logic [31:0] addr, input logic [31:0] val, input logic [15:0] msk,
                     input bit wb, input logic [TW-1:0] wbt, input bit rdy, input bit rsp);
    dt_instruction_valid   = v;
    dt_is_load             = ld;
    dt_is_vector           = vec;
    dt_thread_idx          = thr;
    dt_request_addr        = addr;
    dt_store_value         = randLine();
    dt_store_value[31:0]   = val;
    dt_mask_value          = msk;
    wb_rollback_en         = wb;
    wb_rollback_thread_idx = wbt;
    l2_req_ready           = rdy;
    l2_resp_valid          = rsp;
    l2_resp_data           = (txn_phase == TXN_ACCEPTED && !txn_store) ? memRead(txn_addr) : randLine();
    applyStimulus();
  endtask

  task automatic opLoad(input logic [TW-1:0] thr, input logic [31:0] addr);
    cyc(1, 1, 0, thr, addr, 32'h0, 16'h0, 0, '0, 0, 0);
  endtask

  task automatic l2Cycle(input bit rdy, input bit rsp);
    cyc(0, 1, 0, '0, 32'h0, 32'h0, 16'h0, 0, '0, rdy, rsp);
  endtask

  initial begin
    reset = 1'b1;
    dt_instruction_valid = 0; dt_is_load = 0; dt_is_vector = 0; dt_mask_value = '0;
    dt_thread_idx = '0; dt_request_addr = '0; dt_store_value = '0;
    wb_rollback_en = 0; wb_rollback_thread_idx = '0;
    l2_req_ready = 0; l2_resp_valid = 0; l2_resp_data = '0;
    for (int i = 0; i < 16; i++) d_line[32*i +: 32] = 32'h1111_0000 + i;
    mem[26'h40] = d_line;

    applyStimulus();
    applyStimulus();
    compare("reset_l2_addr", l2_req_addr, 32'h0);
    compare("reset_l2_mask", l2_req_byte_mask, 64'h0);
    compare("reset_load_data", dd_load_data, 512'h0);
    compare("reset_wake_thread", dd_wake_thread_idx, 2'd0);
    reset = 1'b0;

    // Cold load miss suspends thread 1 and requests a fill of 0x1000.
    opLoad(2'd1, 32'h0000_1000);
    compare("lit_miss_rollback", dd_rollback_en, 1'b1);
    compare("lit_miss_suspend", dd_suspend_thread, 1'b1);
    compare("lit_fill_req_valid", l2_req_valid, 1'b1);
    compare("lit_fill_req_addr", l2_req_addr, 32'h0000_1000);
    compare("lit_fill_req_store", l2_req_store, 1'b0);
    l2Cycle(1, 0);
    compare("lit_req_dropped", l2_req_valid, 1'b0);
    for (int i = 0; i < 5; i++) l2Cycle(0, 0);
    l2Cycle(0, 1);
    compare("lit_wake_en", dd_wake_en, 1'b1);
    compare("lit_wake_thread", dd_wake_thread_idx, 2'd1);
    opLoad(2'd1, 32'h0000_1000);
    compare("lit_reissue_valid", dd_instruction_valid, 1'b1);
    compare("lit_reissue_data", dd_load_data, d_line);

    // Scalar store hit to word 2, then read it back.
    cyc(1, 0, 0, 2'd0, 32'h0000_1008, 32'hDEAD_BEEF, 16'h0, 0, '0, 0, 0);
    compare("lit_store_valid", dd_instruction_valid, 1'b1);
    compare("lit_store_mask", l2_req_byte_mask, 64'h0000_0000_0000_0F00);
    compare("lit_store_word2", l2_req_data[95:64], 32'hDEAD_BEEF);
    compare("lit_store_flag", l2_req_store, 1'b1);
    l2Cycle(1, 0);
    l2Cycle(0, 0);
    l2Cycle(0, 1);
    compare("lit_store_no_wake", dd_wake_en, 1'b0);
    opLoad(2'd0, 32'h0000_1008);
    compare("lit_merged_word2", dd_load_data[95:64], 32'hDEAD_BEEF);
    compare("lit_merged_word3", dd_load_data[127:96], 32'h1111_0003);
    opLoad(2'd2, 32'h0000_1010);
`ifdef DCACHE_PERF_COUNTERS_EN
    compare("lit_perf_hits", dd_perf_hit_count, 32'd3);
    compare("lit_perf_misses", dd_perf_miss_count, 32'd1);
`endif

    // Second miss while a fill is outstanding must not suspend or issue another request.
    opLoad(2'd0, 32'h0000_2000);
    opLoad(2'd2, 32'h0000_3000);
    compare("lit_busy_rollback", dd_rollback_en, 1'b1);
    compare("lit_busy_no_suspend", dd_suspend_thread, 1'b0);
    compare("lit_busy_addr_kept", l2_req_addr, 32'h0000_2000);
    for (int i = 0; i < 10; i++) begin
      l2Cycle(0, 0);
      compare("lit_stall_valid", l2_req_valid, 1'b1);
      compare("lit_stall_addr", l2_req_addr, 32'h0000_2000);
    end
    l2Cycle(1, 0);
    // Writeback squashes the latched thread during the fill response; the wake still goes out.
    cyc(0, 1, 0, '0, 32'h0, 32'h0, 16'h0, 1, 2'd0, 0, 1);
    compare("lit_wake_despite_squash", dd_wake_en, 1'b1);
    compare("lit_wake_thread0", dd_wake_thread_idx, 2'd0);
    cyc(1, 0, 0, 2'd3, 32'h0000_1000, 32'h1234_5678, 16'h0, 1, 2'd3, 0, 0);
    compare("lit_squash_no_valid", dd_instruction_valid, 1'b0);
    compare("lit_squash_no_rollback", dd_rollback_en, 1'b0);
    compare("lit_squash_no_l2", l2_req_valid, 1'b0);

    // Reset during an accepted fill: late response is ignored and lines are invalid.
    opLoad(2'd1, 32'h0000_4000);
    l2Cycle(1, 0);
    l2Cycle(0, 0);
    reset = 1'b1;
    l2Cycle(0, 0);
    reset = 1'b0;
    l2Cycle(0, 1);
    compare("lit_no_wake_after_reset", dd_wake_en, 1'b0);
    opLoad(2'd1, 32'h0000_1000);
    compare("lit_invalid_after_reset", dd_rollback_en, 1'b1);
    l2Cycle(1, 0);
    l2Cycle(0, 1);

    for (int n = 0; n < 4000; n++) begin
      reset                  = ($urandom_range(0, 599) == 0);
      dt_instruction_valid   = ($urandom_range(0, 9) < 7);
      dt_is_load             = $urandom_range(0, 1);
      dt_is_vector           = $urandom_range(0, 1);
      dt_mask_value          = 16'($urandom);
      dt_thread_idx          = 2'($urandom_range(0, 3));
      dt_request_addr        = (32'($urandom_range(1, 3)) << 12) | (32'($urandom_range(0, 3)) << 6) |
                               (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      dt_store_value         = randLine();
      wb_rollback_en         = ($urandom_range(0, 6) == 0);
      wb_rollback_thread_idx = 2'($urandom_range(0, 3));
      l2_req_ready           = ($urandom_range(0, 2) != 0);
      l2_resp_valid          = 1'b0;
      l2_resp_data           = randLine();
      if (txn_phase == TXN_ACCEPTED) begin
        if (txn_delay == 0) begin
          l2_resp_valid = 1'b1;
          if (!txn_store) l2_resp_data = memRead(txn_addr);
        end else begin
          txn_delay--;
        end
      end
      applyStimulus();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
